slave_fifo_msg_deframer: RTL and testbench
==========================================

Name: slave_fifo_msg_deframer

Overview:
- Receive-side counterpart of the FX2 slave-FIFO message framer.
- Consumes the 16-bit word stream read out of the slave FIFO (one word per DIN_VALID strobe).
- Hunts for the frame header: prefix 0xBBBB, then src_len marker 0xCCCC. Forwards exactly MSG_LEN payload words to a downstream FIFO, then reports completion or a framing error.
- Sits between the slave-FIFO read path and the serializer input FIFO.

Parameters:
PREFIX_WORD, 16'hBBBB, first header word
SRCLEN_WORD, 16'hCCCC, second header word
GAP_TIMEOUT, 255, max idle cycles between words inside a frame before abort (max 65535)
ERR_HOLD, 2, cycles spent in ERROR before re-hunting

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
DIN  in  16  word read from slave FIFO
DIN_VALID  in  1  DIN valid for this cycle, single-cycle strobe per word
MSG_LEN  in  8  payload words per frame, sampled when 0xCCCC is accepted
FIFO_FULL  in  1  downstream FIFO full
DOUT  out  16  payload word to downstream FIFO
WR_REQ  out  1  write strobe for DOUT
MSG_DONE  out  1  one-cycle pulse: complete frame delivered
MSG_ERR  out  1  one-cycle pulse: frame aborted
state_monitor  out  3  current state encoding
payload_counter  out  8  payload words accepted in current frame

Behaviour:
- Reset (RST=1 at a CLK edge): state=HUNT, WR_REQ=0, DOUT=0, MSG_DONE=0, MSG_ERR=0, payload_counter=0, len_reg=0, gap counter=0. Reset mid-frame discards the partial frame; no MSG_ERR pulse.
- State encoding: HUNT=0, HDR=1, PAYLOAD=2, DONE=3, ERROR=4.
- HUNT:
  - DIN_VALID and DIN==PREFIX_WORD -> HDR.
  - All other words are dropped silently.
- HDR:
  - DIN_VALID and DIN==SRCLEN_WORD -> latch len_reg=MSG_LEN, clear payload_counter.
    - len_reg==0 -> DONE.
    - Otherwise -> PAYLOAD.
  - DIN_VALID and DIN==PREFIX_WORD -> stay in HDR (repeated prefix).
  - DIN_VALID with any other word -> ERROR.
- PAYLOAD:
  - Each DIN_VALID word registers DOUT=DIN, WR_REQ=1 on the next cycle (latency 1), and payload_counter+1.
  - When the accepted word makes payload_counter==len_reg -> DONE on the same edge.
  - Payload words equal to 0xBBBB/0xCCCC are ordinary data; no resync inside payload.
  - FIFO_FULL high on the cycle a valid word arrives -> word dropped, WR_REQ stays 0, -> ERROR.
- DONE: MSG_DONE=1 for exactly one cycle, payload_counter cleared, -> HUNT.
  - A DIN_VALID word arriving in the DONE cycle is evaluated as in HUNT, so back-to-back frames are not lost.
- ERROR: MSG_ERR=1 on the entry cycle only. Hold for ERR_HOLD cycles ignoring DIN, then clear payload_counter and go -> HUNT.
- Gap timeout, HDR and PAYLOAD only:
  - 16-bit counter clears on each DIN_VALID and increments otherwise.
  - Reaching GAP_TIMEOUT -> ERROR.
  - The counter is held at 0 in HUNT, DONE and ERROR.
- WR_REQ is a one-cycle pulse per accepted word. It never asserts outside PAYLOAD or the cycle immediately following it.
- MSG_LEN changes after the latch point have no effect on the current frame.
- payload_counter is 8 bits and never wraps: the maximum is MSG_LEN=255.

Decomposition:
- Shared package: state encodings (HUNT..ERROR), PREFIX_WORD/SRCLEN_WORD constants, shared with the write-side framer.
- One natural sub-module: gap_timeout_counter (clear, enable, limit, expired).

Test Plan:
1. MSG_LEN=3; words BBBB,CCCC,0001,0002,0003 -> three WR_REQ pulses with DOUT 0001/0002/0003, each one cycle after its strobe; MSG_DONE pulses once; payload_counter returns to 0.
2. Garbage 1234,BBBB,BBBB,CCCC then 2 payload words with MSG_LEN=2 -> 1234 dropped, frame delivered, MSG_DONE=1, no MSG_ERR.
3. BBBB,5555 -> MSG_ERR pulse; ERROR held 2 cycles; then BBBB,CCCC,AAAA with MSG_LEN=1 -> DOUT=AAAA, MSG_DONE.
4. MSG_LEN=4; after 2 payload words, idle GAP_TIMEOUT cycles -> MSG_ERR, exactly 2 WR_REQ pulses total, state_monitor returns to 0.
5. FIFO_FULL=1 coincident with 2nd payload word -> no WR_REQ for that word, MSG_ERR pulse, no MSG_DONE.
6. Two frames back-to-back with the next BBBB arriving in the DONE cycle -> both frames delivered, two MSG_DONE pulses. RST asserted mid-payload -> all outputs 0 next cycle, no MSG_ERR.

Source files
------------

// File: rtl/slave_fifo_msg_deframer_pkg.sv
// -----------------------------------------------------------------------------
// slave_fifo_msg_deframer_pkg
//   Definitions shared by the slave-FIFO message framer (write side) and the
//   deframer (read side): header word values and the state encoding reported
//   on state_monitor.
// -----------------------------------------------------------------------------
package slave_fifo_msg_deframer_pkg;

    // Header words that open every frame.
    localparam logic [15:0] DEF_PREFIX_WORD = 16'hBBBB;
    localparam logic [15:0] DEF_SRCLEN_WORD = 16'hCCCC;

    // The numeric values are visible on state_monitor, so they are fixed.
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } deframer_state_e;

endpackage

// File: rtl/slave_fifo_msg_deframer_if.sv
// -----------------------------------------------------------------------------
// slave_fifo_msg_deframer_if
//   Bundles the deframer's data path and status signals.
//   master : drives the slave-FIFO word stream (DIN, DIN_VALID), the frame
//            length (MSG_LEN) and the downstream FIFO_FULL flag; observes the rest.
//   slave  : the deframer; drives DOUT/WR_REQ toward the downstream FIFO,
//            the MSG_DONE/MSG_ERR pulses, state_monitor and payload_counter.
// -----------------------------------------------------------------------------
interface slave_fifo_msg_deframer_if;
    logic [15:0] DIN;
    logic        DIN_VALID;
    logic [7:0]  MSG_LEN;
    logic        FIFO_FULL;
    logic [15:0] DOUT;
    logic        WR_REQ;
    logic        MSG_DONE;
    logic        MSG_ERR;
    logic [2:0]  state_monitor;
    logic [7:0]  payload_counter;

    modport master (
        output DIN, DIN_VALID, MSG_LEN, FIFO_FULL,
        input  DOUT, WR_REQ, MSG_DONE, MSG_ERR, state_monitor, payload_counter
    );

    modport slave (
        input  DIN, DIN_VALID, MSG_LEN, FIFO_FULL,
        output DOUT, WR_REQ, MSG_DONE, MSG_ERR, state_monitor, payload_counter
    );
endinterface

// File: rtl/slave_fifo_msg_deframer_gap_timeout_counter.sv
// -----------------------------------------------------------------------------
// slave_fifo_msg_deframer_gap_timeout_counter
//   Counts idle cycles between words while a frame is open.
//   clk, rst : clock, synchronous active-high reset
//   enable   : frame is open; when low the count is held at zero
//   clear    : a word arrived this cycle; restarts the idle count
//   limit    : number of consecutive idle cycles that aborts the frame
//   expired  : this cycle is the limit-th idle cycle in a row; the owner
//              acts on it at the coming edge
// -----------------------------------------------------------------------------
module slave_fifo_msg_deframer_gap_timeout_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge, independent of statement order between blocks.
    always_ff @(posedge clk) begin
        if (rst || !enable || clear) begin
            count <= '0;
        end else if (count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // Widened so that limit=65535 compares without overflow.
    assign expired = enable && !clear &&
                     (({1'b0, count} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/slave_fifo_msg_deframer.sv
// -----------------------------------------------------------------------------
// slave_fifo_msg_deframer
//   Receive-side counterpart of the slave-FIFO message framer. Hunts for the
//   PREFIX_WORD / SRCLEN_WORD header, forwards exactly MSG_LEN payload words
//   to a downstream FIFO and reports completion (MSG_DONE) or an aborted
//   frame (MSG_ERR).
//   CLK, RST        : clock, synchronous active-high reset
//   bus.DIN         : word from the slave FIFO, valid when bus.DIN_VALID
//   bus.MSG_LEN     : payload length, latched when the SRCLEN word is taken
//   bus.FIFO_FULL   : downstream FIFO cannot take a word
//   bus.DOUT/WR_REQ : payload word and its one-cycle write strobe
//   bus.MSG_DONE    : one-cycle pulse, frame delivered
//   bus.MSG_ERR     : one-cycle pulse, frame aborted
//   bus.state_monitor, bus.payload_counter : observability
// -----------------------------------------------------------------------------
module slave_fifo_msg_deframer
    import slave_fifo_msg_deframer_pkg::*;
#(
    parameter logic [15:0] PREFIX_WORD = DEF_PREFIX_WORD,
    parameter logic [15:0] SRCLEN_WORD = DEF_SRCLEN_WORD,
    parameter int          GAP_TIMEOUT = 255,
    parameter int          ERR_HOLD    = 2
) (
    input logic                      CLK,
    input logic                      RST,
    slave_fifo_msg_deframer_if.slave bus
);

    localparam logic [15:0] GAP_LIMIT = 16'(GAP_TIMEOUT);
    // Last value of the hold counter before leaving ERROR.
    localparam logic [15:0] ERR_LAST  = (ERR_HOLD > 1) ? 16'(ERR_HOLD - 1) : 16'd0;

    deframer_state_e state;
    logic [15:0]     dout_q;
    logic            wr_req_q;
    logic            msg_done_q;
    logic            msg_err_q;
    logic [7:0]      payload_cnt;
    logic [7:0]      len_reg;
    logic [15:0]     err_cnt;
    logic            gap_expired;

    wire        din_valid = bus.DIN_VALID;
    wire [15:0] din       = bus.DIN;
    wire [7:0]  cnt_inc   = payload_cnt + 8'd1;

    slave_fifo_msg_deframer_gap_timeout_counter u_gap (
        .clk     (CLK),
        .rst     (RST),
        .enable  ((state == ST_HDR) || (state == ST_PAYLOAD)),
        .clear   (din_valid),
        .limit   (GAP_LIMIT),
        .expired (gap_expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_HUNT;
            dout_q      <= '0;
            wr_req_q    <= 1'b0;
            msg_done_q  <= 1'b0;
            msg_err_q   <= 1'b0;
            payload_cnt <= '0;
            len_reg     <= '0;
            err_cnt     <= '0;
        end else begin
            // Pulses default low; each branch raises them for a single cycle.
            wr_req_q   <= 1'b0;
            msg_done_q <= 1'b0;
            msg_err_q  <= 1'b0;
            err_cnt    <= '0;

            case (state)
                // DONE also accepts a new prefix so back-to-back frames survive.
                ST_HUNT, ST_DONE: begin
                    if (state == ST_DONE) begin
                        payload_cnt <= '0;
                    end
                    if (din_valid && din == PREFIX_WORD) begin
                        state <= ST_HDR;
                    end else begin
                        state <= ST_HUNT;
                    end
                end

                ST_HDR: begin
                    if (din_valid) begin
                        if (din == SRCLEN_WORD) begin
                            len_reg     <= bus.MSG_LEN;
                            payload_cnt <= '0;
                            if (bus.MSG_LEN == 8'd0) begin
                                state      <= ST_DONE;
                                msg_done_q <= 1'b1;
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end else if (din != PREFIX_WORD) begin
                            state     <= ST_ERROR;
                            msg_err_q <= 1'b1;
                        end
                    end else if (gap_expired) begin
                        state     <= ST_ERROR;
                        msg_err_q <= 1'b1;
                    end
                end

                // Header values inside the payload are plain data.
                ST_PAYLOAD: begin
                    if (din_valid) begin
                        if (bus.FIFO_FULL) begin
                            state     <= ST_ERROR;
                            msg_err_q <= 1'b1;
                        end else begin
                            dout_q      <= din;
                            wr_req_q    <= 1'b1;
                            payload_cnt <= cnt_inc;
                            if (cnt_inc == len_reg) begin
                                state      <= ST_DONE;
                                msg_done_q <= 1'b1;
                            end
                        end
                    end else if (gap_expired) begin
                        state     <= ST_ERROR;
                        msg_err_q <= 1'b1;
                    end
                end

                ST_ERROR: begin
                    if (err_cnt >= ERR_LAST) begin
                        state       <= ST_HUNT;
                        payload_cnt <= '0;
                    end else begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end

                default: state <= ST_HUNT;
            endcase
        end
    end

    assign bus.DOUT            = dout_q;
    assign bus.WR_REQ          = wr_req_q;
    assign bus.MSG_DONE        = msg_done_q;
    assign bus.MSG_ERR         = msg_err_q;
    assign bus.state_monitor   = state;
    assign bus.payload_counter = payload_cnt;

endmodule

// File: tb/tb_slave_fifo_msg_deframer.sv
// -----------------------------------------------------------------------------
// tb_slave_fifo_msg_deframer
//   Directed bench for slave_fifo_msg_deframer. A frame-level reference model
//   predicts every output each cycle; literal checks pin key cycles.
// -----------------------------------------------------------------------------
module tb_slave_fifo_msg_deframer;

    localparam int          GAP  = 255;
    localparam int          HOLD = 2;
    localparam logic [15:0] PFX  = 16'hBBBB;
    localparam logic [15:0] SLN  = 16'hCCCC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slave_fifo_msg_deframer_if bus ();

    slave_fifo_msg_deframer #(
        .GAP_TIMEOUT (GAP),
        .ERR_HOLD    (HOLD)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level view) ----------------
    typedef enum int {M_SEEK, M_PREFIX, M_DATA, M_FINISHED, M_ABORT} mphase_e;

    mphase_e     ph = M_SEEK;
    int          remaining, idle_cycles, abort_left;
    logic [15:0] e_dout = '0;
    logic        e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int          e_pc = 0;

    function automatic int phase_code(input mphase_e p);
        case (p)
            M_SEEK:     return 0;
            M_PREFIX:   return 1;
            M_DATA:     return 2;
            M_FINISHED: return 3;
            default:    return 4;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit abort_now;
        abort_now = 1'b0;
        if (rst) begin
            ph = M_SEEK; e_dout = '0; e_wr = 0; e_done = 0; e_err = 0; e_pc = 0;
        end else begin
            e_wr = 0; e_done = 0; e_err = 0;
            case (ph)
                M_SEEK, M_FINISHED: begin
                    if (ph == M_FINISHED) e_pc = 0;
                    if (bus.DIN_VALID && bus.DIN == PFX) begin
                        ph = M_PREFIX; idle_cycles = 0;
                    end else ph = M_SEEK;
                end
                M_PREFIX: begin
                    if (bus.DIN_VALID) begin
                        idle_cycles = 0;
                        if (bus.DIN == SLN) begin
                            remaining = int'(bus.MSG_LEN);
                            e_pc = 0;
                            if (remaining == 0) begin ph = M_FINISHED; e_done = 1; end
                            else ph = M_DATA;
                        end else if (bus.DIN != PFX) abort_now = 1'b1;
                    end else begin
                        idle_cycles++;
                        if (idle_cycles == GAP) abort_now = 1'b1;
                    end
                end
                M_DATA: begin
                    if (bus.DIN_VALID) begin
                        idle_cycles = 0;
                        if (bus.FIFO_FULL) abort_now = 1'b1;
                        else begin
                            e_dout = bus.DIN; e_wr = 1; e_pc++; remaining--;
                            if (remaining == 0) begin ph = M_FINISHED; e_done = 1; end
                        end
                    end else begin
                        idle_cycles++;
                        if (idle_cycles == GAP) abort_now = 1'b1;
                    end
                end
                default: begin
                    abort_left--;
                    if (abort_left == 0) begin ph = M_SEEK; e_pc = 0; end
                end
            endcase
            if (abort_now) begin ph = M_ABORT; e_err = 1; abort_left = HOLD; end
        end
    end

    // ---------------- per-cycle compare + pulse bookkeeping ----------------
    int          cnt_wr, cnt_done, cnt_err;
    logic [15:0] dout_log[$];

    always @(negedge clk) begin
        if (checking) begin
            check("DOUT",            32'(bus.DOUT),            32'(e_dout));
            check("WR_REQ",          32'(bus.WR_REQ),          32'(e_wr));
            check("MSG_DONE",        32'(bus.MSG_DONE),        32'(e_done));
            check("MSG_ERR",         32'(bus.MSG_ERR),         32'(e_err));
            check("state_monitor",   32'(bus.state_monitor),   32'(phase_code(ph)));
            check("payload_counter", 32'(bus.payload_counter), 32'(e_pc));
            cnt_wr   += int'(bus.WR_REQ);
            cnt_done += int'(bus.MSG_DONE);
            cnt_err  += int'(bus.MSG_ERR);
            if (bus.WR_REQ) dout_log.push_back(bus.DOUT);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic [15:0] d);
        bus.DIN_VALID = v;
        bus.DIN       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] d);
        step(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    task automatic clear_counts();
        cnt_wr = 0; cnt_done = 0; cnt_err = 0;
        dout_log.delete();
    endtask

    // ---------------- directed tests ----------------
    initial begin
        bus.DIN = '0; bus.DIN_VALID = 1'b0; bus.MSG_LEN = '0; bus.FIFO_FULL = 1'b0;
        rst = 1'b1;
        idle(1);
        checking = 1'b1;
        check("reset state",   32'(bus.state_monitor), 0);
        check("reset WR_REQ",  32'(bus.WR_REQ), 0);
        check("reset DOUT",    32'(bus.DOUT), 0);
        check("reset counter", 32'(bus.payload_counter), 0);
        idle(1);
        rst = 1'b0;

        // 1: basic three-word frame; MSG_LEN moves after the latch point
        clear_counts();
        bus.MSG_LEN = 8'd3;
        word(PFX); word(SLN);
        bus.MSG_LEN = 8'd7;
        word(16'h0001);
        check("t1 first WR_REQ", 32'(bus.WR_REQ), 1);
        check("t1 first DOUT",   32'(bus.DOUT), 32'h0001);
        word(16'h0002); word(16'h0003);
        check("t1 DONE state", 32'(bus.state_monitor), 3);
        check("t1 MSG_DONE",   32'(bus.MSG_DONE), 1);
        idle(1);
        check("t1 counter cleared", 32'(bus.payload_counter), 0);
        check("t1 wr pulses",   32'(cnt_wr), 3);
        check("t1 done pulses", 32'(cnt_done), 1);
        check("t1 log[2]",      32'(dout_log[2]), 32'h0003);

        // 2: garbage + repeated prefix
        clear_counts();
        bus.MSG_LEN = 8'd2;
        word(16'h1234); word(PFX); word(PFX); word(SLN);
        word(16'h0011); word(16'h0022);
        idle(2);
        check("t2 wr pulses",   32'(cnt_wr), 2);
        check("t2 done pulses", 32'(cnt_done), 1);
        check("t2 err pulses",  32'(cnt_err), 0);

        // 3: bad second header word, error hold ignores words, then recover
        clear_counts();
        word(PFX); word(16'h5555);
        check("t3 MSG_ERR",     32'(bus.MSG_ERR), 1);
        check("t3 ERROR state", 32'(bus.state_monitor), 4);
        word(PFX);
        check("t3 still ERROR", 32'(bus.state_monitor), 4);
        idle(1);
        check("t3 back to HUNT", 32'(bus.state_monitor), 0);
        bus.MSG_LEN = 8'd1;
        word(PFX); word(SLN); word(16'hAAAA);
        check("t3 DOUT",     32'(bus.DOUT), 32'hAAAA);
        check("t3 MSG_DONE", 32'(bus.MSG_DONE), 1);
        idle(1);

        // 4: gap timeout inside payload
        clear_counts();
        bus.MSG_LEN = 8'd4;
        word(PFX); word(SLN); word(16'h0001); word(16'h0002);
        idle(GAP - 1);
        check("t4 not yet expired", 32'(bus.state_monitor), 2);
        idle(1);
        check("t4 MSG_ERR", 32'(bus.MSG_ERR), 1);
        idle(HOLD);
        check("t4 back to HUNT", 32'(bus.state_monitor), 0);
        check("t4 wr pulses",    32'(cnt_wr), 2);

        // 5: downstream full on second payload word
        clear_counts();
        bus.MSG_LEN = 8'd3;
        word(PFX); word(SLN); word(16'h0001);
        bus.FIFO_FULL = 1'b1;
        word(16'h0002);
        bus.FIFO_FULL = 1'b0;
        check("t5 dropped WR_REQ", 32'(bus.WR_REQ), 0);
        check("t5 MSG_ERR",        32'(bus.MSG_ERR), 1);
        idle(3);
        check("t5 wr pulses",   32'(cnt_wr), 1);
        check("t5 done pulses", 32'(cnt_done), 0);

        // 6: back-to-back frames, header values as payload, reset mid-frame
        clear_counts();
        bus.MSG_LEN = 8'd2;
        word(PFX); word(SLN); word(16'h0101); word(16'h0102);
        word(PFX);
        check("t6 prefix in DONE", 32'(bus.state_monitor), 1);
        word(SLN); word(PFX); word(SLN);
        check("t6 header as data", 32'(bus.DOUT), 32'hCCCC);
        idle(1);
        check("t6 done pulses", 32'(cnt_done), 2);
        check("t6 wr pulses",   32'(cnt_wr), 4);
        clear_counts();
        bus.MSG_LEN = 8'd5;
        word(PFX); word(SLN); word(16'h0301);
        rst = 1'b1;
        word(16'h0302);
        rst = 1'b0;
        check("t6 rst DOUT",    32'(bus.DOUT), 0);
        check("t6 rst WR_REQ",  32'(bus.WR_REQ), 0);
        check("t6 rst state",   32'(bus.state_monitor), 0);
        check("t6 rst counter", 32'(bus.payload_counter), 0);
        idle(2);
        check("t6 rst no MSG_ERR", 32'(cnt_err), 0);

        // zero-length frame
        clear_counts();
        bus.MSG_LEN = 8'd0;
        word(PFX); word(SLN);
        check("len0 MSG_DONE", 32'(bus.MSG_DONE), 1);
        idle(1);
        check("len0 no WR_REQ", 32'(cnt_wr), 0);

        // maximum-length frame
        clear_counts();
        bus.MSG_LEN = 8'd255;
        word(PFX); word(SLN);
        for (int i = 1; i <= 255; i++) word(16'(i));
        check("len255 counter",  32'(bus.payload_counter), 255);
        check("len255 MSG_DONE", 32'(bus.MSG_DONE), 1);
        idle(1);
        check("len255 wr pulses", 32'(cnt_wr), 255);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
